// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM pipeline stage controller.
package mem_stage_ctrl_pkg;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  localparam logic [31:0] BUS_ERR_DATA    = 32'hDEADBEEF;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: load a new instruction, insert a bubble, or reset.
module mem_wb_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              bubble,
  input  logic [DATA_W-1:0] read_data_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [REG_W-1:0]  write_reg_in,
  input  logic              memtoreg_in,
  input  logic              regwrite_in,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] alu_result,
  output logic [REG_W-1:0]  write_reg,
  output logic              memtoreg,
  output logic              regwrite
);

  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic [DATA_W-1:0] alu_result_q, alu_result_d;
  logic [REG_W-1:0]  write_reg_q, write_reg_d;
  logic              memtoreg_q, memtoreg_d;
  logic              regwrite_q, regwrite_d;

  // A bubble only kills the control bits; data fields hold their last value.
  always_comb begin
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    write_reg_d  = write_reg_q;
    memtoreg_d   = memtoreg_q;
    regwrite_d   = regwrite_q;
    if (load) begin
      read_data_d  = read_data_in;
      alu_result_d = alu_result_in;
      write_reg_d  = write_reg_in;
      memtoreg_d   = memtoreg_in;
      regwrite_d   = regwrite_in;
    end else if (bubble) begin
      memtoreg_d = 1'b0;
      regwrite_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= '0;
      memtoreg_q   <= 1'b0;
      regwrite_q   <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
      memtoreg_q   <= memtoreg_d;
      regwrite_q   <= regwrite_d;
    end
  end

  assign read_data  = read_data_q;
  assign alu_result = alu_result_q;
  assign write_reg  = write_reg_q;
  assign memtoreg   = memtoreg_q;
  assign regwrite   = regwrite_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: runs loads/stores over a req/ack data bus, stalls
// the upstream pipeline while an access is outstanding, feeds MEM/WB.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_W    = 5,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] MEMALUResult,
  input  logic [DATA_W-1:0] MEMWriteData,
  input  logic [REG_W-1:0]  MEM_WriteReg,
  input  logic              MEMMemRead,
  input  logic              MEMMemWrite,
  input  logic              MEMMemtoReg,
  input  logic              MEMRegWrite,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              MemStall,
  output logic [DATA_W-1:0] WBReadData,
  output logic [DATA_W-1:0] WBALUResult,
  output logic [REG_W-1:0]  WB_WriteReg,
  output logic              WBMemtoReg,
  output logic              WBRegWrite,
  output logic              MisalignErr,
  output logic              BusErr
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              misalign_q, misalign_d;
  logic              bus_err_q, bus_err_d;

  logic              memop;
  logic              stall;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout;
  logic [DATA_W-1:0] wb_read_data;

  always_comb begin
    memop        = MEMMemRead | MEMMemWrite;
    cnt_inc      = wait_cnt_q + CNT_W'(1);
    timeout      = (cnt_inc == CNT_W'(MAX_WAIT));
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    misalign_d   = misalign_q;
    bus_err_d    = bus_err_q;
    stall        = 1'b0;
    wb_read_data = '0;

    case (state_q)
      MEM_IDLE: begin
        if (memop) begin
          stall      = 1'b1;
          state_d    = MEM_ACCESS;
          wait_cnt_d = '0;
          addr_d     = MEMALUResult & DATA_W'(WORD_ALIGN_MASK);
          wdata_d    = MEMWriteData;
          we_d       = MEMMemWrite;
          if (MEMALUResult[1:0] != 2'b00) misalign_d = 1'b1;
        end
      end
      MEM_ACCESS: begin
        wait_cnt_d = cnt_inc;
        // Ack has priority over a timeout landing in the same cycle.
        if (dmem_ack) begin
          state_d      = MEM_IDLE;
          wait_cnt_d   = '0;
          wb_read_data = we_q ? '0 : dmem_rdata;
        end else if (timeout) begin
          state_d      = MEM_IDLE;
          wait_cnt_d   = '0;
          bus_err_d    = 1'b1;
          wb_read_data = DATA_W'(BUS_ERR_DATA);
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = MEM_IDLE;
    endcase

    if (reset) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MEM_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb_reg (
    .clk           (clk),
    .reset         (reset),
    .load          (~stall),
    .bubble        (stall),
    .read_data_in  (wb_read_data),
    .alu_result_in (MEMALUResult),
    .write_reg_in  (MEM_WriteReg),
    .memtoreg_in   (MEMMemtoReg),
    .regwrite_in   (MEMRegWrite),
    .read_data     (WBReadData),
    .alu_result    (WBALUResult),
    .write_reg     (WB_WriteReg),
    .memtoreg      (WBMemtoReg),
    .regwrite      (WBRegWrite)
  );

  assign dmem_req    = (state_q == MEM_ACCESS);
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign MemStall    = stall;
  assign MisalignErr = misalign_q;
  assign BusErr      = bus_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed table, reset corner case,
// and random instruction stream against a per-instruction timing model.
module tb_mem_stage_ctrl;

  localparam int unsigned MAX_WAIT = 15;
  localparam logic [31:0] BUS_ERR  = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] MEMALUResult, MEMWriteData;
  logic [4:0]  MEM_WriteReg;
  logic        MEMMemRead, MEMMemWrite, MEMMemtoReg, MEMRegWrite;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        MemStall;
  logic [31:0] WBReadData, WBALUResult;
  logic [4:0]  WB_WriteReg;
  logic        WBMemtoReg, WBRegWrite, MisalignErr, BusErr;

  mem_stage_ctrl #(.DATA_W(32), .REG_W(5), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .MEMALUResult(MEMALUResult), .MEMWriteData(MEMWriteData), .MEM_WriteReg(MEM_WriteReg),
    .MEMMemRead(MEMMemRead), .MEMMemWrite(MEMMemWrite), .MEMMemtoReg(MEMMemtoReg),
    .MEMRegWrite(MEMRegWrite),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .MemStall(MemStall),
    .WBReadData(WBReadData), .WBALUResult(WBALUResult), .WB_WriteReg(WB_WriteReg),
    .WBMemtoReg(WBMemtoReg), .WBRegWrite(WBRegWrite),
    .MisalignErr(MisalignErr), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, m2r, rw;
    logic [31:0] alu, wdata;
    logic [4:0]  wreg;
    int          ack_at;   // ACCESS cycle (1-based) carrying the ack; 0 = never
    logic [31:0] rdata;
    logic [31:0] exp_rd;
    int          exp_cyc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected MEM/WB contents and sticky flags
  logic [31:0] e_rd, e_alu;
  logic [4:0]  e_reg;
  logic        e_m2r, e_rw, e_mis, e_bus;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_wb();
    check("WBReadData",  WBReadData,          e_rd);
    check("WBALUResult", WBALUResult,         e_alu);
    check("WB_WriteReg", 32'(WB_WriteReg),    32'(e_reg));
    check("WBMemtoReg",  32'(WBMemtoReg),     32'(e_m2r));
    check("WBRegWrite",  32'(WBRegWrite),     32'(e_rw));
    check("MisalignErr", 32'(MisalignErr),    32'(e_mis));
    check("BusErr",      32'(BusErr),         32'(e_bus));
  endtask

  task automatic retire(input vec_t v, input logic [31:0] rd);
    e_rd  = rd;
    e_alu = v.alu;
    e_reg = v.wreg;
    e_m2r = v.m2r;
    e_rw  = v.rw;
  endtask

  // Drives one EX/MEM instruction from its first MEM cycle until it retires.
  task automatic run_instr(input vec_t v, output int occ);
    logic memop, done, ack;
    memop        = v.rd | v.wr;
    MEMMemRead   = v.rd;
    MEMMemWrite  = v.wr;
    MEMMemtoReg  = v.m2r;
    MEMRegWrite  = v.rw;
    MEMALUResult = v.alu;
    MEMWriteData = v.wdata;
    MEM_WriteReg = v.wreg;
    dmem_rdata   = v.rdata;
    dmem_ack     = 1'($urandom_range(0, 1));  // no request out: must be ignored
    occ = -1;
    #4;
    check("stall_first", 32'(MemStall), 32'(memop));
    check("req_first",   32'(dmem_req), 32'd0);
    check_wb();
    if (!MemStall) occ = 1;
    if (!memop) retire(v, 32'd0);
    else begin
      e_m2r = 1'b0;
      e_rw  = 1'b0;
      if (v.alu[1:0] != 2'b00) e_mis = 1'b1;
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    if (memop) begin
      done = 1'b0;
      for (int k = 1; k <= int'(MAX_WAIT) && !done; k++) begin
        ack = (k == v.ack_at);
        dmem_ack = ack;
        #4;
        check("req_access", 32'(dmem_req),   32'd1);
        check("dmem_addr",  dmem_addr,       {v.alu[31:2], 2'b00});
        check("dmem_we",    32'(dmem_we),    32'(v.wr));
        check("dmem_wdata", dmem_wdata,      v.wdata);
        check("stall_acc",  32'(MemStall),   32'(!(ack || k == int'(MAX_WAIT))));
        check_wb();
        if (!MemStall && occ < 0) occ = k + 1;
        if (ack) begin
          retire(v, v.wr ? 32'd0 : v.rdata);
          done = 1'b1;
        end else if (k == int'(MAX_WAIT)) begin
          retire(v, BUS_ERR);
          e_bus = 1'b1;
          done  = 1'b1;
        end else begin
          e_m2r = 1'b0;
          e_rw  = 1'b0;
        end
        @(posedge clk); #1;
        dmem_ack = 1'b0;
      end
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic m2r, input logic rw,
                              input logic [31:0] alu, input logic [31:0] wdata,
                              input logic [4:0] wreg, input int ack_at,
                              input logic [31:0] rdata, input logic [31:0] exp_rd,
                              input int exp_cyc);
    vec_t v;
    v.rd = rd; v.wr = wr; v.m2r = m2r; v.rw = rw;
    v.alu = alu; v.wdata = wdata; v.wreg = wreg; v.ack_at = ack_at;
    v.rdata = rdata; v.exp_rd = exp_rd; v.exp_cyc = exp_cyc;
    return v;
  endfunction

  task automatic drive_zero();
    MEMMemRead = 0; MEMMemWrite = 0; MEMMemtoReg = 0; MEMRegWrite = 0;
    MEMALUResult = '0; MEMWriteData = '0; MEM_WriteReg = '0;
    dmem_ack = 0; dmem_rdata = '0;
  endtask

  task automatic zero_model();
    e_rd = '0; e_alu = '0; e_reg = '0; e_m2r = 0; e_rw = 0; e_mis = 0; e_bus = 0;
  endtask

  vec_t tbl[8];
  vec_t v;
  int   occ, exp_occ, kind, r;

  initial begin
    tbl[0] = mk(0, 0, 0, 1, 32'h10, 32'h0,    5'd8,  0,  32'h0,    32'h0,    1);
    tbl[1] = mk(1, 0, 1, 1, 32'h40, 32'h0,    5'd9,  3,  32'h1234, 32'h1234, 4);
    tbl[2] = mk(0, 1, 0, 0, 32'h44, 32'hCAFE, 5'd0,  1,  32'h0,    32'h0,    2);
    tbl[3] = mk(1, 0, 1, 1, 32'h48, 32'h0,    5'd10, 15, 32'hA5A5, 32'hA5A5, 16);
    tbl[4] = mk(1, 0, 1, 1, 32'h43, 32'h0,    5'd11, 2,  32'h55,   32'h55,   3);
    tbl[5] = mk(1, 1, 0, 0, 32'h80, 32'h77,   5'd0,  2,  32'h999,  32'h0,    3);
    tbl[6] = mk(1, 0, 1, 1, 32'h4C, 32'h0,    5'd12, 0,  32'h1,    BUS_ERR,  16);
    tbl[7] = mk(0, 0, 0, 1, 32'h20, 32'h0,    5'd13, 0,  32'h0,    32'h0,    1);

    // Reset with a memop presented: no stall, everything cleared
    reset = 1'b1;
    drive_zero();
    MEMMemRead = 1'b1;
    zero_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    #3;
    check("stall_in_reset", 32'(MemStall), 32'd0);
    check("req_in_reset",   32'(dmem_req), 32'd0);
    check("we_in_reset",    32'(dmem_we),  32'd0);
    check("addr_in_reset",  dmem_addr,     32'd0);
    check_wb();
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_instr(tbl[i], occ);
      check($sformatf("tbl%0d_occupancy", i), 32'(occ), 32'(tbl[i].exp_cyc));
      check($sformatf("tbl%0d_readdata", i), WBReadData, tbl[i].exp_rd);
    end

    // Reset in the 2nd ACCESS cycle abandons the load; a late ack is ignored
    v = mk(1, 0, 1, 1, 32'h100, 32'h0, 5'd7, 0, 32'h3333, 32'h0, 0);
    MEMMemRead = 1; MEMMemWrite = 0; MEMMemtoReg = 1; MEMRegWrite = 1;
    MEMALUResult = v.alu; MEM_WriteReg = v.wreg; dmem_ack = 0; dmem_rdata = v.rdata;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #3;
    check("rst_acc_stall", 32'(MemStall), 32'd0);
    check("rst_acc_req",   32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_zero();
    dmem_ack = 1'b1;
    dmem_rdata = 32'h3333;
    zero_model();
    #3;
    check("post_rst_req",   32'(dmem_req), 32'd0);
    check("post_rst_stall", 32'(MemStall), 32'd0);
    check("post_rst_addr",  dmem_addr,     32'd0);
    check_wb();
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    #3;
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check_wb();
    @(posedge clk); #1;

    // Random instruction stream
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      v.rd    = (kind == 1) || (kind == 3);
      v.wr    = (kind == 2) || (kind == 3);
      v.m2r   = 1'($urandom_range(0, 1));
      v.rw    = 1'($urandom_range(0, 1));
      v.alu   = $urandom;
      v.wdata = $urandom;
      v.wreg  = 5'($urandom_range(0, 31));
      v.rdata = $urandom;
      r = int'($urandom_range(0, 7));
      v.ack_at = (r == 0) ? 0 : int'($urandom_range(1, MAX_WAIT));
      run_instr(v, occ);
      if (kind == 0)        exp_occ = 1;
      else if (v.ack_at == 0) exp_occ = 1 + int'(MAX_WAIT);
      else                  exp_occ = 1 + v.ack_at;
      check($sformatf("rnd%0d_occupancy", i), 32'(occ), 32'(exp_occ));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
